mulberry_xbar_arb: RTL and testbench

Parametrised successor to the mulberry bus arbitration logic, packaged as a standalone module. It connects P_NUM_MASTERS grapheme masters to P_NUM_SLAVES shared compute slaves (rand, mul, div, and future units) as a crossbar.
- Each slave has its own round-robin arbiter that skips busy slaves, so several slaves can be granted in one cycle.
- Requests are registered and acknowledged explicitly.
- Responses are routed per master, with stall feedback on collisions.
- Out-of-range slave IDs are answered with an error response.

---
 rtl/syn_gpu_pkg.sv | 25 ++
 rtl/mulberry_xbar_arb_if.sv | 45 ++++
 rtl/mulberry_rr_arb.sv | 55 +++++
 rtl/mulberry_xbar_arb.sv | 166 ++++++++++++++++
 tb/tb_mulberry_xbar_arb.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/syn_gpu_pkg.sv
// Shared constants and types for the GPU bus fabric.
//   MID_IDLE / SID_IDLE : the "nobody" value on master / slave ID fields
//   mid_t / sid_t       : ID types at the default fabric widths
//   SID_RAND/MUL/DIV    : legacy slave IDs; slave index = SID - 1
package syn_gpu_pkg;

    localparam int MID_IDLE  = 0;
    localparam int SID_IDLE  = 0;

    localparam int DEF_MID_W = 3;
    localparam int DEF_SID_W = 3;

    typedef logic [DEF_MID_W-1:0] mid_t;
    typedef logic [DEF_SID_W-1:0] sid_t;

    localparam sid_t SID_RAND = 3'd1;
    localparam sid_t SID_MUL  = 3'd2;
    localparam sid_t SID_DIV  = 3'd3;

    // Slave index addressed by a non-idle SID.
    function automatic int sid_to_slave(input int sid);
        return sid - 1;
    endfunction

endpackage

// File: rtl/mulberry_xbar_arb_if.sv
// Bus bundle between the grapheme masters, the compute slaves and the
// crossbar. All per-master / per-slave fields are flat packed vectors,
// element i occupying bits [i*W +: W].
//   xbar   : crossbar view (takes requests and slave responses)
//   master : master-side view (drives m_sid / m_req_data)
//   slave  : slave-side view (drives s_busy / s_rsp_*)
interface mulberry_xbar_arb_if #(
    parameter int P_NUM_MASTERS = 4,
    parameter int P_NUM_SLAVES  = 4,
    parameter int P_BUS_DATA_W  = 32,
    parameter int P_MID_W       = 3,
    parameter int P_SID_W       = 3
);
    logic [P_NUM_MASTERS*P_SID_W-1:0]      m_sid;
    logic [P_NUM_MASTERS*P_BUS_DATA_W-1:0] m_req_data;
    logic [P_NUM_MASTERS-1:0]              m_req_ack;
    logic [P_NUM_MASTERS-1:0]              m_rsp_valid;
    logic [P_NUM_MASTERS-1:0]              m_rsp_err;
    logic [P_NUM_MASTERS*P_BUS_DATA_W-1:0] m_rsp_data;

    logic [P_NUM_SLAVES-1:0]               s_busy;
    logic [P_NUM_SLAVES-1:0]               s_req_valid;
    logic [P_NUM_SLAVES*P_MID_W-1:0]       s_req_mid;
    logic [P_NUM_SLAVES*P_BUS_DATA_W-1:0]  s_req_data;
    logic [P_NUM_SLAVES*P_MID_W-1:0]       s_rsp_mid;
    logic [P_NUM_SLAVES*P_BUS_DATA_W-1:0]  s_rsp_data;
    logic [P_NUM_SLAVES-1:0]               s_rsp_stall;

    modport xbar (
        input  m_sid, m_req_data, s_busy, s_rsp_mid, s_rsp_data,
        output m_req_ack, m_rsp_valid, m_rsp_err, m_rsp_data,
        output s_req_valid, s_req_mid, s_req_data, s_rsp_stall
    );

    modport master (
        output m_sid, m_req_data,
        input  m_req_ack, m_rsp_valid, m_rsp_err, m_rsp_data
    );

    modport slave (
        output s_busy, s_rsp_mid, s_rsp_data,
        input  s_req_valid, s_req_mid, s_req_data, s_rsp_stall
    );

endinterface

// File: rtl/mulberry_rr_arb.sv
// N-way round-robin arbiter with its own pointer register.
//   clk_ir / rst_ih : clock, asynchronous active-high reset (pointer -> 0)
//   req             : request vector
//   en              : arbitration enable; low = no grant, pointer holds
//   gnt             : one-hot grant (combinational, same cycle as req)
// The grant goes to the first requester at or after the pointer in cyclic
// order; on a grant the pointer moves to grantee+1 (wrapping).
module mulberry_rr_arb #(
    parameter int N = 4
) (
    input  logic         clk_ir,
    input  logic         rst_ih,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // Two ordered scans replace a modulo rotation: indices at/after the
    // pointer first, then the ones that wrapped around below it.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        if (en) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (PW'(j) >= ptr_q)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                    ptr_d  = (j == N - 1) ? '0 : PW'(j + 1);
                end
            end
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (PW'(j) < ptr_q)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                    ptr_d  = (j == N - 1) ? '0 : PW'(j + 1);
                end
            end
        end
    end

    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mulberry_xbar_arb.sv
// Master-to-slave crossbar with per-slave round-robin arbitration.
//   clk_ir / rst_ih : clock, asynchronous active-high reset
//   bus (xbar)      : m_sid/m_req_data in, m_req_ack/m_rsp_* out,
//                     s_busy/s_rsp_mid/s_rsp_data in,
//                     s_req_*/s_rsp_stall out
// Requests: a grant in cycle t gives m_req_ack and s_req_* at t+1.
// SIDs above the slave count are acked at t+1 and answered with an error
// response at t+2. Responses: lowest-index slave wins per master, data
// registered one cycle; losers are stalled combinationally.
module mulberry_xbar_arb
    import syn_gpu_pkg::*;
#(
    parameter int P_NUM_MASTERS = 4,
    parameter int P_NUM_SLAVES  = 4,
    parameter int P_BUS_DATA_W  = 32,
    parameter int P_MID_W       = 3,
    parameter int P_SID_W       = 3
) (
    input  logic              clk_ir,
    input  logic              rst_ih,
    mulberry_xbar_arb_if.xbar bus
);
    localparam int NM = P_NUM_MASTERS;
    localparam int NS = P_NUM_SLAVES;
    localparam int DW = P_BUS_DATA_W;
    localparam int MW = P_MID_W;
    localparam int SW = P_SID_W;

    logic [SW-1:0]          m_sid_w   [NM];
    logic [MW-1:0]          s_rsp_mid_w [NS];
    logic [NS-1:0][NM-1:0]  cand;
    logic [NS-1:0][NM-1:0]  gnt;
    logic [NM-1:0]          inv_req;
    logic [NM-1:0]          taken;
    logic [NS-1:0]          stall;

    logic [NM-1:0]          ack_q, ack_d;
    logic [NM-1:0]          err_pend_q, err_pend_d;
    logic [NM-1:0]          rsp_valid_q, rsp_valid_d;
    logic [NM-1:0]          rsp_err_q, rsp_err_d;
    logic [NM*DW-1:0]       rsp_data_q, rsp_data_d;
    logic [NS-1:0]          req_valid_q, req_valid_d;
    logic [NS*MW-1:0]       req_mid_q, req_mid_d;
    logic [NS*DW-1:0]       req_data_q, req_data_d;

    genvar gi;

    generate
        for (gi = 0; gi < NM; gi++) begin : g_msid
            assign m_sid_w[gi] = bus.m_sid[gi*SW +: SW];
        end
        for (gi = 0; gi < NS; gi++) begin : g_smid
            assign s_rsp_mid_w[gi] = bus.s_rsp_mid[gi*MW +: MW];
        end
    endgenerate

    // Candidate decode. A master whose ack is visible this cycle still shows
    // the request just accepted, so it is kept out of arbitration.
    always_comb begin
        cand    = '0;
        inv_req = '0;
        for (int m = 0; m < NM; m++) begin
            if (!ack_q[m] && (m_sid_w[m] != SW'(SID_IDLE))) begin
                if (m_sid_w[m] > SW'(NS)) begin
                    inv_req[m] = 1'b1;
                end
                for (int s = 0; s < NS; s++) begin
                    if (m_sid_w[m] == SW'(s + 1)) begin
                        cand[s][m] = 1'b1;
                    end
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NS; gi++) begin : g_arb
            mulberry_rr_arb #(
                .N (NM)
            ) u_arb (
                .clk_ir (clk_ir),
                .rst_ih (rst_ih),
                .req    (cand[gi]),
                .en     (~bus.s_busy[gi]),
                .gnt    (gnt[gi])
            );
        end
    endgenerate

    // Request path: each master targets at most one slave, so at most one
    // grant per master; invalid-SID requests are acked without a slave.
    always_comb begin
        ack_d       = inv_req;
        err_pend_d  = inv_req;
        req_valid_d = '0;
        req_mid_d   = '0;
        req_data_d  = '0;
        for (int s = 0; s < NS; s++) begin
            for (int m = 0; m < NM; m++) begin
                if (gnt[s][m]) begin
                    ack_d[m]                = 1'b1;
                    req_valid_d[s]          = 1'b1;
                    req_mid_d[s*MW +: MW]   = MW'(m + 1);
                    req_data_d[s*DW +: DW]  = bus.m_req_data[m*DW +: DW];
                end
            end
        end
    end

    // Response path: a pending error response claims its master first, then
    // slaves in index order; anything addressed to a claimed master stalls.
    always_comb begin
        taken       = err_pend_q;
        rsp_valid_d = err_pend_q;
        rsp_err_d   = err_pend_q;
        rsp_data_d  = '0;
        stall       = '0;
        for (int s = 0; s < NS; s++) begin
            for (int m = 0; m < NM; m++) begin
                if ((s_rsp_mid_w[s] != MW'(MID_IDLE)) && (s_rsp_mid_w[s] == MW'(m + 1))) begin
                    if (taken[m]) begin
                        stall[s] = 1'b1;
                    end else begin
                        taken[m]               = 1'b1;
                        rsp_valid_d[m]         = 1'b1;
                        rsp_data_d[m*DW +: DW] = bus.s_rsp_data[s*DW +: DW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            ack_q       <= '0;
            err_pend_q  <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_data_q  <= '0;
            req_valid_q <= '0;
            req_mid_q   <= '0;
            req_data_q  <= '0;
        end else begin
            ack_q       <= ack_d;
            err_pend_q  <= err_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            req_valid_q <= req_valid_d;
            req_mid_q   <= req_mid_d;
            req_data_q  <= req_data_d;
        end
    end

    assign bus.m_req_ack   = ack_q;
    assign bus.m_rsp_valid = rsp_valid_q;
    assign bus.m_rsp_err   = rsp_err_q;
    assign bus.m_rsp_data  = rsp_data_q;
    assign bus.s_req_valid = req_valid_q;
    assign bus.s_req_mid   = req_mid_q;
    assign bus.s_req_data  = req_data_q;
    // The only combinational output; forced low so every output reads 0
    // while reset is held.
    assign bus.s_rsp_stall = stall & {NS{~rst_ih}};

endmodule

// File: tb/tb_mulberry_xbar_arb.sv
module tb_mulberry_xbar_arb;
    import syn_gpu_pkg::*;

    localparam int NM = 4;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam int SW = 3;

    logic clk;
    logic rst;

    mulberry_xbar_arb_if bus ();

    mulberry_xbar_arb dut (
        .clk_ir (clk),
        .rst_ih (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus state
    int           msid   [NM];
    logic [DW-1:0] mdata [NM];
    bit           busy   [NS];
    int           srmid  [NS];
    logic [DW-1:0] srdata [NS];
    bit           chg    [NM];

    // reference model state
    int  ptr [NS];
    int  nptr [NS];
    bit  errp [NM];
    bit  prev_stall [NS];
    logic [NM-1:0]    exp_ack, n_ack, n_errp;
    logic [NS-1:0]    exp_sval, n_sval;
    logic [NS*MW-1:0] exp_smid, n_smid;
    logic [NS*DW-1:0] exp_sdata, n_sdata;
    logic [NM-1:0]    exp_rv, n_rv, exp_re, n_re;
    logic [NM*DW-1:0] exp_rd, n_rd;
    logic [NS-1:0]    exp_stall;
    logic [NS-1:0]    last_stall;

    int exp_seq [4] = '{1, 3, 4, 1};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bus();
        for (int m = 0; m < NM; m++) begin
            bus.m_sid[m*SW +: SW]      = SW'(msid[m]);
            bus.m_req_data[m*DW +: DW] = mdata[m];
        end
        for (int s = 0; s < NS; s++) begin
            bus.s_busy[s]              = busy[s];
            bus.s_rsp_mid[s*MW +: MW]  = MW'(srmid[s]);
            bus.s_rsp_data[s*DW +: DW] = srdata[s];
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NS; s++) begin
            ptr[s] = 0;
            prev_stall[s] = 1'b0;
        end
        for (int m = 0; m < NM; m++) errp[m] = 1'b0;
        exp_ack = '0; exp_sval = '0; exp_smid = '0; exp_sdata = '0;
        exp_rv = '0; exp_re = '0; exp_rd = '0; exp_stall = '0;
    endfunction

    // Behaviour for one cycle from the current inputs: who wins each slave,
    // which masters get acked, what response each master sees next.
    function automatic void model_eval();
        bit got [NM];
        n_ack = '0; n_errp = '0; n_sval = '0; n_smid = '0; n_sdata = '0;
        n_rv = '0; n_re = '0; n_rd = '0; exp_stall = '0;
        for (int s = 0; s < NS; s++) nptr[s] = ptr[s];
        for (int m = 0; m < NM; m++) begin
            if (!exp_ack[m] && msid[m] > NS) begin
                n_ack[m] = 1'b1;
                n_errp[m] = 1'b1;
            end
        end
        for (int s = 0; s < NS; s++) begin
            bit done;
            done = 1'b0;
            if (!busy[s]) begin
                for (int k = 0; k < NM; k++) begin
                    int m;
                    m = (ptr[s] + k) % NM;
                    if (!done && msid[m] == s + 1 && !exp_ack[m]) begin
                        done = 1'b1;
                        n_ack[m] = 1'b1;
                        n_sval[s] = 1'b1;
                        n_smid[s*MW +: MW] = MW'(m + 1);
                        n_sdata[s*DW +: DW] = mdata[m];
                        nptr[s] = (m + 1) % NM;
                    end
                end
            end
        end
        for (int m = 0; m < NM; m++) begin
            got[m] = errp[m];
            n_rv[m] = errp[m];
            n_re[m] = errp[m];
        end
        for (int s = 0; s < NS; s++) begin
            if (srmid[s] >= 1 && srmid[s] <= NM) begin
                int m;
                m = srmid[s] - 1;
                if (got[m]) begin
                    exp_stall[s] = 1'b1;
                end else begin
                    got[m] = 1'b1;
                    n_rv[m] = 1'b1;
                    n_rd[m*DW +: DW] = srdata[s];
                end
            end
        end
    endfunction

    function automatic void model_commit();
        for (int s = 0; s < NS; s++) begin
            ptr[s] = nptr[s];
            prev_stall[s] = exp_stall[s];
        end
        for (int m = 0; m < NM; m++) errp[m] = n_errp[m];
        exp_ack = n_ack; exp_sval = n_sval; exp_smid = n_smid; exp_sdata = n_sdata;
        exp_rv = n_rv; exp_re = n_re; exp_rd = n_rd;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_ack"},    bus.m_req_ack,   exp_ack);
        chk({tag, "_sval"},   bus.s_req_valid, exp_sval);
        chk({tag, "_smid"},   bus.s_req_mid,   exp_smid);
        chk({tag, "_sdata"},  bus.s_req_data,  exp_sdata);
        chk({tag, "_rvalid"}, bus.m_rsp_valid, exp_rv);
        chk({tag, "_rerr"},   bus.m_rsp_err,   exp_re);
        chk({tag, "_rdata"},  bus.m_rsp_data,  exp_rd);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack0"},   bus.m_req_ack,   '0);
        chk({tag, "_sval0"},  bus.s_req_valid, '0);
        chk({tag, "_smid0"},  bus.s_req_mid,   '0);
        chk({tag, "_sdata0"}, bus.s_req_data,  '0);
        chk({tag, "_rv0"},    bus.m_rsp_valid, '0);
        chk({tag, "_re0"},    bus.m_rsp_err,   '0);
        chk({tag, "_rd0"},    bus.m_rsp_data,  '0);
        chk({tag, "_stall0"}, bus.s_rsp_stall, '0);
    endtask

    // Called just after a rising edge with the stimulus arrays set for the
    // coming cycle; returns just after the next rising edge.
    task automatic cycle(input string tag);
        drive_bus();
        model_eval();
        @(negedge clk);
        last_stall = bus.s_rsp_stall;
        chk({tag, "_stall"}, last_stall, exp_stall);
        @(posedge clk);
        #1;
        model_commit();
        check_regs(tag);
    endtask

    task automatic all_idle();
        for (int m = 0; m < NM; m++) begin
            msid[m] = 0;
            mdata[m] = '0;
            chg[m] = 1'b0;
        end
        for (int s = 0; s < NS; s++) begin
            busy[s] = 1'b0;
            srmid[s] = 0;
            srdata[s] = '0;
        end
    endtask

    initial begin
        rst = 1'b1;
        all_idle();
        drive_bus();
        model_reset();
        #12;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // three masters contend for the multiplier
        msid[0] = SID_MUL; msid[2] = SID_MUL; msid[3] = SID_MUL;
        for (int m = 0; m < NM; m++) mdata[m] = 32'h1000 + m;
        for (int i = 0; i < 6; i++) begin
            cycle("t1");
            if (i < 4) chk("t1_mid_seq", bus.s_req_mid[MW +: MW], exp_seq[i]);
        end
        all_idle();
        cycle("t1_idle");

        // two slaves granted in the same cycle
        msid[0] = SID_RAND; msid[1] = SID_DIV;
        mdata[0] = 32'hCAFE0000; mdata[1] = 32'h0000BEEF;
        cycle("t2");
        chk("t2_sval_pair", bus.s_req_valid, 4'b0101);
        chk("t2_ack_pair", bus.m_req_ack, 4'b0011);
        cycle("t2_hold");
        all_idle();

        // busy slave blocks the grant
        msid[1] = SID_MUL; mdata[1] = 32'h11112222; busy[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("t3_busy");
            chk("t3_no_ack", bus.m_req_ack[1], 1'b0);
            chk("t3_no_sval", bus.s_req_valid[1], 1'b0);
        end
        busy[1] = 1'b0;
        cycle("t3_free");
        chk("t3_ack", bus.m_req_ack[1], 1'b1);
        chk("t3_sval", bus.s_req_valid[1], 1'b1);
        cycle("t3_hold");
        all_idle();

        // two slaves answer the same master
        srmid[0] = 2; srdata[0] = 32'hA5;
        srmid[2] = 2; srdata[2] = 32'h5A;
        cycle("t4a");
        chk("t4_stall_vec", last_stall, 4'b0100);
        chk("t4_first", bus.m_rsp_data[DW +: DW], 32'hA5);
        srmid[0] = 0;
        cycle("t4b");
        chk("t4_second", bus.m_rsp_data[DW +: DW], 32'h5A);
        chk("t4_valid2", bus.m_rsp_valid[1], 1'b1);
        srmid[2] = 0;
        cycle("t4c");

        // invalid SID
        msid[3] = 7; mdata[3] = 32'hDEADDEAD;
        cycle("t5a");
        chk("t5_ack", bus.m_req_ack[3], 1'b1);
        chk("t5_novalid", bus.m_rsp_valid[3], 1'b0);
        cycle("t5b");
        chk("t5_valid", bus.m_rsp_valid[3], 1'b1);
        chk("t5_err", bus.m_rsp_err[3], 1'b1);
        chk("t5_data", bus.m_rsp_data[3*DW +: DW], 32'h0);
        msid[3] = 0;
        cycle("t5c");

        // reset in the middle of a contested burst
        for (int m = 0; m < NM; m++) begin
            msid[m] = SID_RAND;
            mdata[m] = 32'h2000 + m;
        end
        srmid[0] = 1; srdata[0] = 32'h77;
        srmid[1] = 1; srdata[1] = 32'h88;
        cycle("t6a");
        cycle("t6b");
        #2;
        rst = 1'b1;
        #1;
        check_zero("t6_async");
        all_idle();
        drive_bus();
        model_reset();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("t6_release");
        msid[1] = SID_RAND; msid[2] = SID_RAND; msid[3] = SID_RAND;
        cycle("t6c");
        chk("t6_first_grant", bus.s_req_mid[0 +: MW], 3'd2);
        cycle("t6_hold");
        all_idle();
        cycle("t6_idle");

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < NM; m++) begin
                if (chg[m] || msid[m] == 0) begin
                    msid[m] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
                    mdata[m] = $urandom;
                end
                chg[m] = exp_ack[m];
            end
            for (int s = 0; s < NS; s++) begin
                busy[s] = ($urandom_range(0, 3) == 0);
                if (!prev_stall[s]) begin
                    srmid[s] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
                    srdata[s] = $urandom;
                end
            end
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
